pipe_stage_skid: RTL and testbench

Parametrised inter-stage pipeline register with a valid/ready handshake, carrying `NUM_FIELDS` words of `DATA_WIDTH` bits between adjacent stages (e.g. Fetch→Decode: Instr, PCPlus4, PC).
- Replaces hand-written EN/CLR stage registers.
- A 2-entry skid buffer lets the upstream ready be registered, so backpressure timing does not chain across stages.
- Adds synchronous flush (bubble insertion) and a saturating stall-cycle counter.

---
 rtl/pipe_stage_skid.sv | 152 +++++++++++++++
 tb/tb_pipe_stage_skid.sv | 267 ++++++++++++++++++++++++++
 2 files changed

// File: rtl/pipe_stage_skid.sv
// pipe_stage_skid
// Inter-stage pipeline register with a valid/ready handshake. It carries
// NUM_FIELDS words of DATA_WIDTH bits. It also provides a synchronous flush,
// which inserts a zero bubble, and a saturating stall-cycle counter.
//
// Build option: define PIPE_SKID_EN to add a second (skid) entry. With the
// skid entry, ReadyF is driven straight from a flop. Without it, ReadyF is
// ReadyD | ~ValidD (combinational).
//
// Ports
//   CLK         in   rising-edge clock
//   RST_N       in   asynchronous active-low reset
//   FLUSH       in   synchronous flush, active-high, highest priority
//   ValidF      in   upstream payload valid
//   ReadyF      out  stage can accept this cycle
//   DataF       in   upstream payload, field k at [k*DATA_WIDTH +: DATA_WIDTH]
//   ValidD      out  downstream payload valid
//   ReadyD      in   downstream accepts this cycle
//   DataD       out  downstream payload
//   StallCount  out  saturating count of cycles with ValidD & ~ReadyD
//
// state   | meaning
// --------+--------------------------------------------
// S_EMPTY | main register invalid
// S_FULL  | main register valid, skid empty
// S_SKID  | main and skid both valid (PIPE_SKID_EN only)

module pipe_stage_skid #(
    parameter int DATA_WIDTH = 32,
    parameter int NUM_FIELDS = 3,
    parameter int CNT_WIDTH  = 16
) (
    input  logic                             CLK,
    input  logic                             RST_N,
    input  logic                             FLUSH,
    input  logic                             ValidF,
    output logic                             ReadyF,
    input  logic [NUM_FIELDS*DATA_WIDTH-1:0] DataF,
    output logic                             ValidD,
    input  logic                             ReadyD,
    output logic [NUM_FIELDS*DATA_WIDTH-1:0] DataD,
    output logic [CNT_WIDTH-1:0]             StallCount
);

    typedef enum logic [1:0] {
        S_EMPTY = 2'd0,
        S_FULL  = 2'd1,
        S_SKID  = 2'd2
    } state_t;

    state_t                            r_state;
    state_t                            w_state_nxt;
    logic [NUM_FIELDS*DATA_WIDTH-1:0]  r_main;
    logic [NUM_FIELDS*DATA_WIDTH-1:0]  w_main_nxt;
    logic [CNT_WIDTH-1:0]              r_stall;
    logic                              w_accept;
    logic                              w_deliver;

`ifdef PIPE_SKID_EN
    logic [NUM_FIELDS*DATA_WIDTH-1:0]  r_skid;
    logic [NUM_FIELDS*DATA_WIDTH-1:0]  w_skid_nxt;
    logic                              r_ready_f;

    // Flop output only, so backpressure does not ripple through stages.
    assign ReadyF = r_ready_f;
`else
    assign ReadyF = ReadyD | ~ValidD;
`endif

    assign ValidD     = (r_state != S_EMPTY);
    assign DataD      = r_main;
    assign StallCount = r_stall;
    assign w_accept   = ValidF & ReadyF;
    assign w_deliver  = ValidD & ReadyD;

    always_ff @(posedge CLK or negedge RST_N) begin
        if (!RST_N) begin
            r_state <= S_EMPTY;
            r_main  <= '0;
`ifdef PIPE_SKID_EN
            r_skid    <= '0;
            r_ready_f <= 1'b1;
`endif
        end else begin
            r_state <= w_state_nxt;
            r_main  <= w_main_nxt;
`ifdef PIPE_SKID_EN
            r_skid    <= w_skid_nxt;
            r_ready_f <= (w_state_nxt != S_SKID);
`endif
        end
    end

    always_comb begin
        w_state_nxt = r_state;
        w_main_nxt  = r_main;
`ifdef PIPE_SKID_EN
        w_skid_nxt  = r_skid;
`endif
        if (FLUSH) begin
            // A same-cycle accept is dropped. Both entries are zeroed so a NOP bubble is presented.
            w_state_nxt = S_EMPTY;
            w_main_nxt  = '0;
`ifdef PIPE_SKID_EN
            w_skid_nxt  = '0;
`endif
        end else begin
            case (r_state)
                S_EMPTY: begin
                    if (w_accept) begin
                        w_main_nxt  = DataF;
                        w_state_nxt = S_FULL;
                    end
                end
                S_FULL: begin
                    if (w_deliver && w_accept) begin
                        w_main_nxt = DataF;
                    end else if (w_deliver) begin
                        // DataD keeps its last value. Only ValidD drops.
                        w_state_nxt = S_EMPTY;
`ifdef PIPE_SKID_EN
                    end else if (w_accept) begin
                        w_skid_nxt  = DataF;
                        w_state_nxt = S_SKID;
`endif
                    end
                end
`ifdef PIPE_SKID_EN
                S_SKID: begin
                    if (w_deliver) begin
                        w_main_nxt  = r_skid;
                        w_state_nxt = S_FULL;
                    end
                end
`endif
                default: begin
                    w_state_nxt = S_EMPTY;
                end
            endcase
        end
    end

    // The stall counter ignores FLUSH. Only reset clears it.
    always_ff @(posedge CLK or negedge RST_N) begin
        if (!RST_N) begin
            r_stall <= '0;
        end else if (ValidD && !ReadyD && (r_stall != {CNT_WIDTH{1'b1}})) begin
            r_stall <= r_stall + CNT_WIDTH'(1);
        end
    end

endmodule

// File: tb/tb_pipe_stage_skid.sv
module tb_pipe_stage_skid;

    localparam int W = 96;

    logic         CLK;
    logic         RST_N;
    logic         FLUSH;
    logic         ValidF;
    logic         ReadyF;
    logic [W-1:0] DataF;
    logic         ValidD;
    logic         ReadyD;
    logic [W-1:0] DataD;
    logic [15:0]  StallCount;

    logic         s_ready_f;
    logic         s_valid_d;
    logic [W-1:0] s_data_d;
    logic [2:0]   s_stall;

    int total = 0;
    int bad   = 0;
    logic [W-1:0] sb_q[$];
    logic [W-1:0] exp_v;

    pipe_stage_skid dut (
        .CLK(CLK), .RST_N(RST_N), .FLUSH(FLUSH),
        .ValidF(ValidF), .ReadyF(ReadyF), .DataF(DataF),
        .ValidD(ValidD), .ReadyD(ReadyD), .DataD(DataD),
        .StallCount(StallCount)
    );

    pipe_stage_skid #(.CNT_WIDTH(3)) dut_small (
        .CLK(CLK), .RST_N(RST_N), .FLUSH(FLUSH),
        .ValidF(ValidF), .ReadyF(s_ready_f), .DataF(DataF),
        .ValidD(s_valid_d), .ReadyD(ReadyD), .DataD(s_data_d),
        .StallCount(s_stall)
    );

    initial CLK = 1'b0;
    always #5 CLK = ~CLK;

    // Scoreboard. Accepted payloads are queued, and each delivery is compared
    // with the oldest one. A flush or a reset empties the queue.
    always @(negedge CLK) begin
        if (!RST_N || FLUSH) begin
            sb_q.delete();
        end else begin
            if (ValidD && ReadyD) begin
                total++;
                if (sb_q.size() == 0) begin
                    bad++;
                    $display("FAIL sb_unexpected: got DataD=%h, expected no delivery", DataD);
                end else begin
                    exp_v = sb_q.pop_front();
                    if (DataD !== exp_v) begin
                        bad++;
                        $display("FAIL sb_order: got DataD=%h expected %h", DataD, exp_v);
                    end
                end
            end
            if (ValidF && ReadyF) sb_q.push_back(DataF);
        end
    end

    task automatic step();
        @(posedge CLK);
        #1;
    endtask

    task automatic test_reset();
        RST_N = 1'b0; FLUSH = 1'b0; ValidF = 1'b0; ReadyD = 1'b0; DataF = '0;
        #1;
        total++;
        if (ValidD !== 1'b0 || DataD !== '0 || ReadyF !== 1'b1 || StallCount !== 16'd0) begin
            bad++;
            $display("FAIL reset_vals: got V=%b D=%h R=%b S=%0d expected V=0 D=0 R=1 S=0",
                     ValidD, DataD, ReadyF, StallCount);
        end
        step(); step();
        RST_N = 1'b1;
        step();
    endtask

    task automatic test_stall();
        ValidF = 1'b1; DataF = W'(32'h55); ReadyD = 1'b0;
        step();
        ValidF = 1'b0;
        repeat (5) step();
        total++;
        if (StallCount !== 16'd5) begin
            bad++;
            $display("FAIL stall_5: got %0d expected 5", StallCount);
        end
        repeat (5) step();
        total++;
        if (StallCount !== 16'd10) begin
            bad++;
            $display("FAIL stall_10: got %0d expected 10", StallCount);
        end
        total++;
        if (s_stall !== 3'd7) begin
            bad++;
            $display("FAIL stall_sat: got %0d expected 7", s_stall);
        end
        ReadyD = 1'b1;
        step();
        total++;
        if (ValidD !== 1'b0 || StallCount !== 16'd10) begin
            bad++;
            $display("FAIL stall_release: got V=%b S=%0d expected V=0 S=10", ValidD, StallCount);
        end
    endtask

    task automatic test_streaming();
        logic [W-1:0] vals[3];
        logic [15:0]  s0;
        vals[0] = W'(32'h10); vals[1] = W'(32'h14); vals[2] = W'(32'h18);
        s0 = StallCount;
        ReadyD = 1'b1;
        for (int i = 0; i < 3; i++) begin
            ValidF = 1'b1; DataF = vals[i];
            step();
            total++;
            if (ValidD !== 1'b1 || DataD !== vals[i]) begin
                bad++;
                $display("FAIL stream_%0d: got V=%b D=%h expected V=1 D=%h", i, ValidD, DataD, vals[i]);
            end
        end
        ValidF = 1'b0;
        step();
        total++;
        if (ValidD !== 1'b0 || DataD !== vals[2] || StallCount !== s0) begin
            bad++;
            $display("FAIL stream_drain: got V=%b D=%h S=%0d expected V=0 D=%h S=%0d",
                     ValidD, DataD, StallCount, vals[2], s0);
        end
    endtask

`ifdef PIPE_SKID_EN
    task automatic test_skid();
        ReadyD = 1'b1; ValidF = 1'b1; DataF = W'(32'hA);
        step();
        ReadyD = 1'b0; DataF = W'(32'hB);
        step();
        ValidF = 1'b0;
        total++;
        if (ReadyF !== 1'b0 || ValidD !== 1'b1 || DataD !== W'(32'hA)) begin
            bad++;
            $display("FAIL skid_hold: got R=%b V=%b D=%h expected R=0 V=1 D=a", ReadyF, ValidD, DataD);
        end
        step();
        ReadyD = 1'b1;
        step();
        total++;
        if (ReadyF !== 1'b1 || ValidD !== 1'b1 || DataD !== W'(32'hB)) begin
            bad++;
            $display("FAIL skid_release: got R=%b V=%b D=%h expected R=1 V=1 D=b", ReadyF, ValidD, DataD);
        end
        step();
    endtask
`else
    task automatic test_comb_ready();
        ReadyD = 1'b0; ValidF = 1'b1; DataF = W'(32'h40);
        step();
        ValidF = 1'b0;
        #1;
        total++;
        if (ReadyF !== 1'b0) begin
            bad++;
            $display("FAIL comb_ready_low: got %b expected 0", ReadyF);
        end
        ReadyD = 1'b1;
        #1;
        total++;
        if (ReadyF !== 1'b1) begin
            bad++;
            $display("FAIL comb_ready_follow: got %b expected 1", ReadyF);
        end
        ValidF = 1'b1; DataF = W'(32'h30);
        step();
        ValidF = 1'b0;
        total++;
        if (ValidD !== 1'b1 || DataD !== W'(32'h30)) begin
            bad++;
            $display("FAIL comb_push: got V=%b D=%h expected V=1 D=30", ValidD, DataD);
        end
        step();
    endtask
`endif

    task automatic test_flush();
        ReadyD = 1'b0; ValidF = 1'b1; DataF = W'(32'h77);
        step();
`ifdef PIPE_SKID_EN
        DataF = W'(32'h78);
        step();
`endif
        FLUSH = 1'b1; ReadyD = 1'b1; ValidF = 1'b1; DataF = W'(32'hC);
        step();
        FLUSH = 1'b0; ValidF = 1'b0;
        total++;
        if (ValidD !== 1'b0 || DataD !== '0 || ReadyF !== 1'b1) begin
            bad++;
            $display("FAIL flush_bubble: got V=%b D=%h R=%b expected V=0 D=0 R=1", ValidD, DataD, ReadyF);
        end
        step(); step();
        total++;
        if (ValidD !== 1'b0) begin
            bad++;
            $display("FAIL flush_no_c: got V=%b D=%h expected V=0", ValidD, DataD);
        end
    endtask

    task automatic test_async_reset();
        ReadyD = 1'b0; ValidF = 1'b1; DataF = W'(32'h66);
        step();
`ifdef PIPE_SKID_EN
        DataF = W'(32'h67);
        step();
`endif
        ValidF = 1'b0;
        #2;
        RST_N = 1'b0;
        #1;
        total++;
        if (ValidD !== 1'b0 || DataD !== '0 || StallCount !== 16'd0 || ReadyF !== 1'b1) begin
            bad++;
            $display("FAIL async_reset: got V=%b D=%h S=%0d R=%b expected V=0 D=0 S=0 R=1",
                     ValidD, DataD, StallCount, ReadyF);
        end
        sb_q.delete();
        RST_N = 1'b1;
        step();
        ReadyD = 1'b1; ValidF = 1'b1; DataF = W'(32'h20);
        step();
        ValidF = 1'b0;
        total++;
        if (ValidD !== 1'b1 || DataD !== W'(32'h20)) begin
            bad++;
            $display("FAIL post_reset_push: got V=%b D=%h expected V=1 D=20", ValidD, DataD);
        end
        step();
    endtask

    initial begin
        test_reset();
        test_stall();
        test_streaming();
`ifdef PIPE_SKID_EN
        test_skid();
`else
        test_comb_ready();
`endif
        test_flush();
        test_async_reset();
        step();
        total++;
        if (sb_q.size() != 0) begin
            bad++;
            $display("FAIL sb_leftover: got %0d pending expected 0", sb_q.size());
        end
        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
